// File: rtl/lenet_pkg.sv
// Shared LeNet constants: element width, layer-1 feature-map geometry and
// the sequencer state encoding.
package lenet_pkg;

  localparam int BITWIDTH   = 32;
  localparam int CH1        = 2;
  localparam int H1         = 28;
  localparam int W1         = 28;
  localparam int FM1_SIZE   = CH1 * H1 * W1;
  localparam int FM1_ADDR_W = $clog2(FM1_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/relu_out_fifo.sv
// Small output skid FIFO of packed {addr, data} entries; a push and a pop in
// the same cycle are both honoured, even when full.
module relu_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PTR_W-1:0]        wptr_q, rptr_q;
  logic [OCC_W-1:0]        occ_q;
  logic                    do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (occ_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && ((occ_q != OCC_W'(DEPTH)) || do_pop);
  assign head_o  = mem_q[rptr_q];
  assign occ_o   = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= inc(wptr_q);
      end
      if (do_pop) rptr_q <= inc(rptr_q);
      occ_q <= occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/relu_layer_sequencer.sv
// Streams a CHANNELS x HEIGHT x WIDTH map from the source buffer through ReLU
// into the destination buffer, with write backpressure and a clamp counter.
module relu_layer_sequencer #(
  parameter int BITWIDTH   = lenet_pkg::BITWIDTH,
  parameter int CHANNELS   = lenet_pkg::CH1,
  parameter int HEIGHT     = lenet_pkg::H1,
  parameter int WIDTH      = lenet_pkg::W1,
  parameter int ADDR_W     = lenet_pkg::FM1_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [BITWIDTH-1:0] rd_data,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [BITWIDTH-1:0] wr_data,
  output logic [ADDR_W-1:0]   neg_count
);
  import lenet_pkg::*;

  localparam int N     = CHANNELS * HEIGHT * WIDTH;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ADDR_W + BITWIDTH;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                inflight_q;
  logic [ADDR_W-1:0]   neg_q, neg_d;
  logic                issue, room, pop, push, fifo_empty, drained;
  logic [OCC_W-1:0]    occ;
  logic [ENT_W-1:0]    head;
  logic [BITWIDTH-1:0] relu;

  assign push = inflight_q;
  assign relu = rd_data[BITWIDTH-1] ? '0 : rd_data;
  assign pop  = wr_en && wr_ready;
  // Reserve a slot for every read still in flight so the FIFO never overflows.
  assign room = (int'(occ) + int'(inflight_q)) < (FIFO_DEPTH + int'(pop));
  // FIFO will be empty after this edge; lets done follow the last write directly.
  assign drained = (occ == '0) || ((occ == OCC_W'(1)) && pop);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    neg_d    = neg_q;
    issue    = 1'b0;
    if (push && rd_data[BITWIDTH-1]) neg_d = neg_q + 1'b1;
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        rd_cnt_d = '0;
        neg_d    = '0;
      end
      RUN: begin
        issue = room;
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: if (!inflight_q && drained) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      neg_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      neg_q      <= neg_d;
      inflight_q <= issue;
      if (issue) rd_addr_q <= rd_cnt_q;
    end
  end

  relu_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({rd_addr_q, relu}),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .occ_o   (occ)
  );

  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign rd_en              = issue;
  assign rd_addr            = rd_cnt_q;
  assign wr_en              = !fifo_empty;
  assign {wr_addr, wr_data} = wr_en ? head : '0;
  assign neg_count          = neg_q;

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Directed bench: source/destination buffer models, a per-edge write monitor
// and per-run checks against hand-derived counts and cycle numbers.
module tb_relu_layer_sequencer;

  localparam int NEL = 1568;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_ready;
  logic        busy, done, rd_en, wr_en;
  logic [10:0] rd_addr, wr_addr, neg_count;
  logic [31:0] rd_data, wr_data;

  logic [31:0] src [0:2047];
  logic [31:0] dst [0:2047];

  int checks = 0, failures = 0;
  int cyc = 0, e0 = 1 << 30;
  int wr_cnt, rd_total, order_err, data_err, stab_err, max_buf, exp_addr;
  int done_cnt, done_rel, first_rd, first_wr, first_wr_addr, stall_rd;
  int busy_cnt, busy_first, busy_last;
  bit timed_out;
  bit hold_v;
  logic [10:0] hold_a;
  logic [31:0] hold_d;

  always #5 clk = ~clk;

  relu_layer_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .neg_count (neg_count)
  );

  always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

  function automatic logic [31:0] relu_exp(input int a);
    logic [31:0] v;
    v = src[a];
    return v[31] ? 32'd0 : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples the cycle that ends at this edge (cycle index = cyc - e0).
  always @(posedge clk) begin
    int rel;
    cyc++;
    rel = cyc - e0;
    if (rst_n) begin
      if (rd_en) begin
        rd_total++;
        if (first_rd < 0) first_rd = rel;
        if (rel >= 1 && rel <= 20) stall_rd++;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (hold_v && (!wr_en || wr_addr != hold_a || wr_data != hold_d)) stab_err++;
      hold_v = wr_en && !wr_ready;
      hold_a = wr_addr;
      hold_d = wr_data;
      if (wr_en && wr_ready) begin
        if (first_wr < 0) begin
          first_wr      = rel;
          first_wr_addr = int'(wr_addr);
        end
        if (int'(wr_addr) != exp_addr) order_err++;
        if (wr_data != relu_exp(int'(wr_addr))) data_err++;
        dst[wr_addr] = wr_data;
        exp_addr++;
        wr_cnt++;
      end
      if (rd_total - wr_cnt > max_buf) max_buf = rd_total - wr_cnt;
    end
  end

  task automatic load_src(input int kind);
    for (int a = 0; a < 2048; a++) begin
      case (kind)
        0: src[a] = 32'd0;
        3: src[a] = (a % 3 == 0) ? -a : a + 100;
        default: src[a] = 32'hFFFF_FFFF;
      endcase
      dst[a] = 32'hDEAD_BEEF;
    end
    if (kind == 0) begin
      src[0] = 32'd1; src[1] = 32'd2; src[28] = 32'd3; src[29] = -32'sd1145;
    end
    if (kind == 2) begin
      src[783] = 32'h7FFF_FFFF; src[784] = 32'h8000_0000;
    end
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: ready low cycles 1..20
  task automatic run_map(input int mode, input bit inj, input int rst_at);
    int c;
    bit fin;
    @(negedge clk);
    wr_cnt = 0; rd_total = 0; order_err = 0; data_err = 0; stab_err = 0;
    max_buf = 0; exp_addr = 0; done_cnt = 0; done_rel = -1; first_rd = -1;
    first_wr = -1; first_wr_addr = -1; stall_rd = 0; busy_cnt = 0;
    busy_first = -1; busy_last = -1; hold_v = 1'b0; timed_out = 1'b0; fin = 1'b0;
    e0 = cyc + 1;
    for (int k = 0; k < 6000; k++) begin
      c = cyc - e0 + 1;
      start = (c == 0) || (inj && (c == 100 || c == 1571));
      case (mode)
        1:       wr_ready = (c % 4 == 0) || (c % 4 == 3);
        2:       wr_ready = !(c >= 1 && c <= 20);
        default: wr_ready = 1'b1;
      endcase
      if (rst_at > 0 && c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {rd_en, busy, done, wr_en, rd_addr, wr_addr, wr_data, neg_count}, 64'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        fin = 1'b1;
        break;
      end
      if (done_rel >= 0 && c > done_rel + 4) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start    = 1'b0;
    wr_ready = 1'b1;
    timed_out = !fin;
  endtask

  task automatic check_run(input string t, input int exp_neg, input int exp_done);
    chk({t, "_timeout"}, timed_out, 0);
    chk({t, "_wr_cnt"}, wr_cnt, NEL);
    chk({t, "_rd_cnt"}, rd_total, NEL);
    chk({t, "_order_err"}, order_err, 0);
    chk({t, "_data_err"}, data_err, 0);
    chk({t, "_stable_err"}, stab_err, 0);
    chk({t, "_buf_le2"}, max_buf <= 2, 1);
    chk({t, "_done_cnt"}, done_cnt, 1);
    chk({t, "_neg_count"}, neg_count, exp_neg);
    chk({t, "_busy_after"}, busy, 0);
    if (exp_done > 0) begin
      chk({t, "_first_rd"}, first_rd, 1);
      chk({t, "_first_wr"}, first_wr, 3);
      chk({t, "_done_cycle"}, done_rel, exp_done);
      chk({t, "_busy_first"}, busy_first, 1);
      chk({t, "_busy_last"}, busy_last, exp_done);
      chk({t, "_busy_cnt"}, busy_cnt, exp_done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {rd_en, busy, done, wr_en, rd_addr, wr_addr, wr_data, neg_count}, 64'd0);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);

    load_src(0);
    run_map(0, 1'b0, 0);
    check_run("basic", 1, 1571);
    chk("basic_dst0", dst[0], 1);
    chk("basic_dst1", dst[1], 2);
    chk("basic_dst28", dst[28], 3);
    chk("basic_dst29", dst[29], 0);
    chk("basic_dst1567", dst[1567], 0);
    repeat (5) @(negedge clk);
    chk("neg_hold_idle", neg_count, 1);

    load_src(1);
    run_map(0, 1'b0, 0);
    check_run("allneg", 1568, 1571);
    chk("allneg_dst500", dst[500], 0);

    load_src(2);
    run_map(0, 1'b0, 0);
    check_run("maxpos", 1567, 1571);
    chk("maxpos_dst783", dst[783], 32'h7FFF_FFFF);
    chk("maxpos_dst784", dst[784], 0);

    load_src(3);
    run_map(1, 1'b0, 0);
    check_run("toggle", 522, 0);

    run_map(2, 1'b0, 0);
    check_run("stall", 522, 0);
    chk("stall_reads", stall_rd, 2);
    chk("stall_first_wr", first_wr, 21);
    chk("stall_first_addr", first_wr_addr, 0);
    chk("stall_dst1", dst[1], 101);
    chk("stall_dst3", dst[3], 0);

    load_src(0);
    run_map(0, 1'b1, 0);
    check_run("restart_ign", 1, 1571);
    run_map(0, 1'b0, 0);
    check_run("after_ign", 1, 1571);

    load_src(1);
    run_map(0, 1'b0, 500);
    chk("rst_timeout", timed_out, 0);
    repeat (3) @(negedge clk);
    chk("rst_idle", {busy, wr_en, rd_en}, 0);
    load_src(0);
    run_map(0, 1'b0, 0);
    check_run("post_rst", 1, 1571);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_layer_sequencer.md
Name: relu_layer_sequencer

Overview:
- Sequences the layer-1 ReLU activation over a CHANNELS x HEIGHT x WIDTH feature map held in a synchronous buffer (default 2x28x28, 32-bit signed).
- Streams every element in channel/row/column order: read from the source buffer, apply ReLU, write to the destination buffer.
- Handles write-side backpressure and reports completion plus the number of clamped elements.
- Sits between the layer-1 convolution output buffer and the pooling stage's input buffer.

Parameters:
- BITWIDTH, 32, element width (two's-complement signed).
- CHANNELS, 2, feature-map channels.
- HEIGHT, 28, rows per channel.
- WIDTH, 28, columns per row.
- ADDR_W, 11, buffer address width; must satisfy 2**ADDR_W >= CHANNELS*HEIGHT*WIDTH.
- FIFO_DEPTH, 2, output skid-FIFO entries.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to process the map; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  source buffer read strobe.
- rd_addr  out  ADDR_W  source read address.
- rd_data  in  BITWIDTH  source data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  destination write valid.
- wr_ready  in  1  destination accepts the write this cycle.
- wr_addr  out  ADDR_W  destination address.
- wr_data  out  BITWIDTH  ReLU result.
- neg_count  out  ADDR_W  elements clamped in the last or current run.

Behaviour:
- Reset, asynchronous: all outputs 0, FSM=IDLE, counters 0, FIFO empty.
- Linear address = ch*HEIGHT*WIDTH + row*WIDTH + col. Column varies fastest. Addresses come from a running counter, not from multipliers.
- FSM:
  - IDLE: on start -> RUN; clear neg_count and the read counter.
  - RUN: issue reads; after the last read is issued -> DRAIN.
  - DRAIN: when no read is in flight and the FIFO is empty -> DONE.
  - DONE: assert done for 1 cycle -> IDLE.
  - busy = (state != IDLE).
- Read issue rule: rd_en is asserted in RUN when elements remain and (occ + inflight − pop) < FIFO_DEPTH.
  - occ = FIFO occupancy.
  - inflight = rd_en registered from the previous cycle.
  - pop = wr_en && wr_ready.
  - With wr_ready held high, throughput is 1 element per cycle.
- Cycle after rd_en: push {delayed addr, relu(rd_data)} into the FIFO. Simultaneous push and pop is legal.
- ReLU: if rd_data[BITWIDTH-1]==1, result is 0 and neg_count increments; otherwise data passes unchanged. 0 passes as 0; 0x8000_0000 becomes 0.
- wr_en = FIFO not empty; wr_addr and wr_data show the FIFO head. Head and valid stay stable while wr_ready is low.
- Latency: start accepted at edge E0 -> first rd_en in cycle 1 -> first wr_en in cycle 3. With no backpressure, the last write is in cycle N+2 (N = CHANNELS*HEIGHT*WIDTH = 1568) and done is in cycle N+3.
- done rises the cycle after the final write handshake.
- neg_count holds its value after done until the next start.
- Reset mid-run aborts immediately: no done pulse, FIFO contents discarded.
- start asserted in the same cycle as done is ignored.

Decomposition:
- Shared package (lenet_pkg): BITWIDTH, layer-1 dimensions (CH1=2, H1=28, W1=28), derived FM1_SIZE=1568, FM1_ADDR_W=11, and the state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module relu_out_fifo: parameterised FIFO_DEPTH FIFO of {addr, data} with push, pop, occupancy, and the same-cycle push/pop case.

Test Plan:
- Source all zeros except addr0=1, addr1=2, addr28=3, addr29=−1145; wr_ready=1. Pulse start -> 1568 writes with addr0=1, addr1=2, addr28=3, addr29=0, all others 0; neg_count=1; done in cycle 1571; busy high for cycles 1..1571.
- Source filled with −1 in every location -> every write is 0; neg_count=1568; addr 0x7FFF_FFFF at addr 783 passes unchanged when inserted.
- wr_ready toggled 1,0,0,1 repeatedly, with a check each cycle -> no dropped or duplicated addresses; addresses strictly 0..1567 in order; wr_addr and wr_data stable while wr_ready=0; at most 2 elements buffered.
- wr_ready=0 for 20 cycles right after start -> exactly 2 reads are issued before the stall; on release, writes resume with addr0 then addr1.
- start pulsed again while busy, and again in the done cycle -> both ignored; one done pulse; the next start in IDLE runs normally.
- rst_n asserted at cycle 500 mid-run -> all outputs 0 asynchronously; no done. After release plus a new start, a full correct run with neg_count recomputed from 0.
